// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types, port count and parameter defaults for sdram_arbiter
package sdram_arb_pkg;
  localparam int NUM_PORTS          = 3;
  localparam int REFRESH_PERIOD_DEF = 1000;
  localparam int REFRESH_WAIT_DEF   = 7;
  localparam int INIT_WAIT_DEF      = 256;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT_DONE, S_RFSH} state_t;
  typedef logic [1:0] port_idx_t;
  function automatic port_idx_t next_port(input port_idx_t p);
    return (p == port_idx_t'(NUM_PORTS - 1)) ? '0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: client request ports and controller request side of sdram_arbiter
interface sdram_arbiter_if;
  logic        p0_req, p1_req, p2_req;
  logic        p0_we, p1_we, p2_we;
  logic        p0_word, p1_word, p2_word;
  logic [24:0] p0_addr, p1_addr, p2_addr;
  logic [15:0] p0_din, p1_din, p2_din;
  logic [15:0] p0_dout, p1_dout, p2_dout;
  logic        p0_ack, p1_ack, p2_ack;
  logic [24:0] sd_addr;
  logic [15:0] sd_din, sd_dout;
  logic        sd_word, sd_rd, sd_wr, sd_refresh, sd_busy;
  logic        rfsh_overrun;
  modport slave (
    input  p0_req, p1_req, p2_req, p0_we, p1_we, p2_we, p0_word, p1_word, p2_word,
           p0_addr, p1_addr, p2_addr, p0_din, p1_din, p2_din, sd_dout, sd_busy,
    output p0_dout, p1_dout, p2_dout, p0_ack, p1_ack, p2_ack,
           sd_addr, sd_din, sd_word, sd_rd, sd_wr, sd_refresh, rfsh_overrun
  );
  modport master (
    output p0_req, p1_req, p2_req, p0_we, p1_we, p2_we, p0_word, p1_word, p2_word,
           p0_addr, p1_addr, p2_addr, p0_din, p1_din, p2_din, sd_dout, sd_busy,
    input  p0_dout, p1_dout, p2_dout, p0_ack, p1_ack, p2_ack,
           sd_addr, sd_din, sd_word, sd_rd, sd_wr, sd_refresh, rfsh_overrun
  );
endinterface

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick: combinational grant picker over the request vector
// Build option SDRAM_ARB_RR_EN: search starts at i_ptr (round-robin); otherwise fixed p0 > p1 > p2.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  port_idx_t            i_ptr,
  output logic [NUM_PORTS-1:0] o_gnt,
  output port_idx_t            o_idx
);
`ifdef SDRAM_ARB_RR_EN
  port_idx_t w_p;
  // Walk from the farthest candidate back to i_ptr so the nearest requester wins.
  always_comb begin
    o_idx = '0;
    w_p = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_p = port_idx_t'((int'(i_ptr) + k) % NUM_PORTS);
      if (i_req[w_p]) o_idx = w_p;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^i_ptr;
  always_comb o_idx = i_req[0] ? 2'd0 : i_req[1] ? 2'd1 : i_req[2] ? 2'd2 : 2'd0;
`endif
  assign o_gnt = (|i_req) ? NUM_PORTS'(1) << o_idx : '0;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: three client ports onto a single-transaction SDRAM controller with auto-refresh
// Build option SDRAM_ARB_RR_EN: round-robin grants; undefined gives fixed priority p0 > p1 > p2.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int REFRESH_PERIOD = REFRESH_PERIOD_DEF,
  parameter int REFRESH_WAIT   = REFRESH_WAIT_DEF,
  parameter int INIT_WAIT      = INIT_WAIT_DEF
) (
  input logic            clk,
  input logic            reset_n,
  sdram_arbiter_if.slave bus
);
  logic [NUM_PORTS-1:0] w_req, w_we, w_word, w_gnt;
  logic [24:0]          w_addr [NUM_PORTS];
  logic [15:0]          w_din  [NUM_PORTS];
  port_idx_t            w_idx, w_ptr;
  logic                 w_wrap, w_rclr;
  state_t               r_state;
  logic [31:0]          r_cnt, r_rcnt;
  logic                 r_pend, r_over, r_we;
  port_idx_t            r_port;
  logic [NUM_PORTS-1:0] r_gnt, r_ack;
  logic [15:0]          r_dout [NUM_PORTS];
  logic [24:0]          r_sd_addr;
  logic [15:0]          r_sd_din;
  logic                 r_sd_word, r_sd_rd, r_sd_wr, r_sd_refresh;
`ifdef SDRAM_ARB_RR_EN
  port_idx_t            r_ptr;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif
  assign w_req  = {bus.p2_req, bus.p1_req, bus.p0_req};
  assign w_we   = {bus.p2_we, bus.p1_we, bus.p0_we};
  assign w_word = {bus.p2_word, bus.p1_word, bus.p0_word};
  assign w_addr = '{bus.p0_addr, bus.p1_addr, bus.p2_addr};
  assign w_din  = '{bus.p0_din, bus.p1_din, bus.p2_din};
  assign w_wrap = (r_state != S_INIT) && (r_rcnt == 32'(REFRESH_PERIOD - 1));
  assign w_rclr = (r_state == S_RFSH) && (r_cnt == 32'(REFRESH_WAIT - 1));
  sdram_arb_pick u_pick (
    .i_req (w_req),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );
  // A wrap in the same cycle a refresh retires re-arms pending and is not an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_INIT;
      r_cnt        <= '0;
      r_rcnt       <= '0;
      r_pend       <= 1'b0;
      r_over       <= 1'b0;
      r_we         <= 1'b0;
      r_port       <= '0;
      r_gnt        <= '0;
      r_ack        <= '0;
      r_dout       <= '{default: '0};
      r_sd_addr    <= '0;
      r_sd_din     <= '0;
      r_sd_word    <= 1'b0;
      r_sd_rd      <= 1'b0;
      r_sd_wr      <= 1'b0;
      r_sd_refresh <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      r_ptr        <= '0;
`endif
    end else begin
      r_ack        <= '0;
      r_sd_refresh <= 1'b0;
      if (r_state != S_INIT) r_rcnt <= w_wrap ? '0 : r_rcnt + 32'd1;
      if (w_wrap && r_pend && !w_rclr) r_over <= 1'b1;
      r_pend <= w_wrap | (r_pend & ~w_rclr);
      case (r_state)
        S_INIT: begin
          r_cnt <= (r_cnt == 32'(INIT_WAIT - 1)) ? '0 : r_cnt + 32'd1;
          if (r_cnt == 32'(INIT_WAIT - 1)) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (r_pend) begin
            r_sd_refresh <= 1'b1;
            r_state      <= S_RFSH;
          end else if (|w_req) begin
            r_port    <= w_idx;
            r_gnt     <= w_gnt;
            r_we      <= w_we[w_idx];
            r_sd_addr <= w_addr[w_idx];
            r_sd_din  <= w_din[w_idx];
            r_sd_word <= w_word[w_idx];
            r_sd_rd   <= ~w_we[w_idx];
            r_sd_wr   <= w_we[w_idx];
            r_state   <= S_ISSUE;
`ifdef SDRAM_ARB_RR_EN
            r_ptr     <= next_port(w_idx);
`endif
          end
        end
        S_ISSUE: if (bus.sd_busy) r_state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (!bus.sd_busy) begin
            if (!r_we) r_dout[r_port] <= bus.sd_dout;
            r_ack   <= r_gnt;
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RFSH: begin
          r_cnt <= w_rclr ? '0 : r_cnt + 32'd1;
          if (w_rclr) r_state <= S_IDLE;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end
  assign bus.p0_dout      = r_dout[0];
  assign bus.p1_dout      = r_dout[1];
  assign bus.p2_dout      = r_dout[2];
  assign bus.p0_ack       = r_ack[0];
  assign bus.p1_ack       = r_ack[1];
  assign bus.p2_ack       = r_ack[2];
  assign bus.sd_addr      = r_sd_addr;
  assign bus.sd_din       = r_sd_din;
  assign bus.sd_word      = r_sd_word;
  assign bus.sd_rd        = r_sd_rd;
  assign bus.sd_wr        = r_sd_wr;
  assign bus.sd_refresh   = r_sd_refresh;
  assign bus.rfsh_overrun = r_over;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed vector table plus multi-cycle sequences against a CAS-2 controller model
module tb_sdram_arbiter;
  logic clk, reset_n;
  sdram_arbiter_if bus();
  sdram_arbiter #(.REFRESH_PERIOD(50)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: busy rises the edge after a strobe edge, falls 6 cycles later with read data.
  logic        m_busy, m_prev, force_busy;
  int          m_cnt;
  logic [15:0] m_dout, m_rdata;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_prev <= 1'b0;
      m_cnt  <= 0;
      m_dout <= '0;
    end else begin
      m_prev <= bus.sd_rd | bus.sd_wr;
      if ((bus.sd_rd | bus.sd_wr) && !m_prev) begin
        m_busy <= 1'b1;
        m_cnt  <= 5;
      end else if (m_cnt > 0) m_cnt <= m_cnt - 1;
      else if (m_busy) begin
        m_busy <= 1'b0;
        m_dout <= m_rdata;
      end
    end
  end
  assign bus.sd_busy = m_busy | force_busy;
  assign bus.sd_dout = m_dout;

  typedef struct {
    int          port;
    logic        we;
    logic        word;
    logic [24:0] addr;
    logic [15:0] din;
    logic [15:0] rdata;
    logic [15:0] exp_dout;
  } vec_t;
  vec_t vt [6];

  int n_pass = 0, n_tot = 0;
  int g, ac, nord, nref, bad, nack;
  int ord [9];
  int served [3];
  logic [24:0] sa;
  logic [15:0] sdn, dv;
  logic sw, srd, swr;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, a, e);
  endtask

  task automatic drive(input int p, input logic rq, input logic we, input logic wd,
                       input logic [24:0] a, input logic [15:0] d);
    case (p)
      0: begin bus.p0_req = rq; bus.p0_we = we; bus.p0_word = wd; bus.p0_addr = a; bus.p0_din = d; end
      1: begin bus.p1_req = rq; bus.p1_we = we; bus.p1_word = wd; bus.p1_addr = a; bus.p1_din = d; end
      default: begin bus.p2_req = rq; bus.p2_we = we; bus.p2_word = wd; bus.p2_addr = a; bus.p2_din = d; end
    endcase
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? bus.p0_ack : (p == 1) ? bus.p1_ack : bus.p2_ack;
  endfunction

  function automatic logic [15:0] dout_of(input int p);
    return (p == 0) ? bus.p0_dout : (p == 1) ? bus.p1_dout : bus.p2_dout;
  endfunction

  function automatic logic [96:0] outs();
    return {bus.p0_dout, bus.p1_dout, bus.p2_dout, bus.p0_ack, bus.p1_ack, bus.p2_ack,
            bus.sd_addr, bus.sd_din, bus.sd_word, bus.sd_rd, bus.sd_wr, bus.sd_refresh,
            bus.rfsh_overrun};
  endfunction

  // One request on port p; reports the negedge index of the first strobe and of the ack.
  task automatic txn(input int p, input logic we, input logic wd, input logic [24:0] a,
                     input logic [15:0] d, output int og, output int oa, output logic [24:0] osa,
                     output logic [15:0] osd, output logic osw, output logic ord_,
                     output logic owr, output logic [15:0] odv);
    og = -1; oa = -1; osa = '0; osd = '0; osw = 1'b0; ord_ = 1'b0; owr = 1'b0; odv = '0;
    drive(p, 1'b1, we, wd, a, d);
    for (int n = 1; n <= 400 && oa < 0; n++) begin
      @(negedge clk);
      if (og < 0 && (bus.sd_rd || bus.sd_wr)) begin
        og = n; osa = bus.sd_addr; osd = bus.sd_din; osw = bus.sd_word;
        ord_ = bus.sd_rd; owr = bus.sd_wr;
      end
      if (ack_of(p)) begin
        oa = n; odv = dout_of(p);
        drive(p, 1'b0, we, wd, a, d);
      end
    end
    if (oa < 0) drive(p, 1'b0, we, wd, a, d);
  endtask

  initial begin
    vt[0] = '{0, 1'b0, 1'b1, 25'h0000100, 16'h0000, 16'hBEEF, 16'hBEEF};
    vt[1] = '{1, 1'b1, 1'b0, 25'h0000201, 16'h00A5, 16'h1111, 16'h0000};
    vt[2] = '{2, 1'b0, 1'b0, 25'h1FFFFFF, 16'h0000, 16'h1234, 16'h1234};
    vt[3] = '{1, 1'b0, 1'b1, 25'h0000000, 16'h0000, 16'hFFFF, 16'hFFFF};
    vt[4] = '{2, 1'b1, 1'b1, 25'h00ABCDE, 16'h5A5A, 16'h9999, 16'h1234};
    vt[5] = '{0, 1'b0, 1'b1, 25'h0000002, 16'h0000, 16'h0000, 16'h0000};
    reset_n = 1'b0; force_busy = 1'b0; m_rdata = '0;
    for (int p = 0; p < 3; p++) drive(p, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'(outs()), 128'(0));
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m_rdata = vt[i].rdata;
      txn(vt[i].port, vt[i].we, vt[i].word, vt[i].addr, vt[i].din, g, ac, sa, sdn, sw, srd, swr, dv);
      chk($sformatf("v%0d_acked", i), 128'(ac > 0), 128'(1));
      chk($sformatf("v%0d_sd_addr", i), 128'(sa), 128'(vt[i].addr));
      chk($sformatf("v%0d_sd_din", i), 128'(sdn), 128'(vt[i].din));
      chk($sformatf("v%0d_sd_word", i), 128'(sw), 128'(vt[i].word));
      chk($sformatf("v%0d_strobe", i), 128'({srd, swr}), 128'({~vt[i].we, vt[i].we}));
      chk($sformatf("v%0d_dout", i), 128'(dv), 128'(vt[i].exp_dout));
      if (i == 0) begin
        chk("init_grant_cycle", 128'(g), 128'(257));
        chk("init_ack_cycle", 128'(ac), 128'(265));
      end
      if (i == 1) begin
        chk("b2b_grant_cycle", 128'(g), 128'(1));
        chk("b2b_ack_cycle", 128'(ac), 128'(9));
      end
      @(negedge clk);
      chk($sformatf("v%0d_ack_single", i), 128'(ack_of(vt[i].port)), 128'(0));
    end
    repeat (4) @(negedge clk);
    nord = 0;
    for (int p = 0; p < 3; p++) begin
      served[p] = 0;
      drive(p, 1'b1, 1'b0, 1'b1, 25'(p * 4), '0);
    end
    for (int n = 0; n < 400 && nord < 9; n++) begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        if (ack_of(p)) begin
          ord[nord] = p;
          nord++;
          served[p]++;
          if (served[p] == 3) drive(p, 1'b0, 1'b0, 1'b1, 25'(p * 4), '0);
        end
      end
    end
    chk("contend_count", 128'(nord), 128'(9));
`ifdef SDRAM_ARB_RR_EN
    for (int i = 1; i < 9; i++) chk($sformatf("rr_order_%0d", i), 128'(ord[i]), 128'((ord[i - 1] + 1) % 3));
`else
    for (int i = 0; i < 9; i++) chk($sformatf("fixed_order_%0d", i), 128'(ord[i]), 128'(i / 3));
`endif
    repeat (4) @(negedge clk);
    nref = 0; bad = 0; nack = 0;
    drive(2, 1'b1, 1'b0, 1'b1, 25'h40, '0);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (bus.p2_ack) nack++;
      if (bus.sd_refresh) begin
        nref++;
        if (bus.sd_rd || bus.sd_wr || bus.sd_busy) bad++;
      end
    end
    drive(2, 1'b0, 1'b0, 1'b1, 25'h40, '0);
    chk("rfsh_rate", 128'(nref >= 9 && nref <= 11), 128'(1));
    chk("rfsh_bus_idle", 128'(bad), 128'(0));
    chk("rfsh_p2_served", 128'(nack >= 30), 128'(1));
    chk("rfsh_no_overrun", 128'(bus.rfsh_overrun), 128'(0));
    repeat (20) @(negedge clk);
    force_busy = 1'b1;
    fork
      begin
        repeat (120) @(negedge clk);
        force_busy = 1'b0;
      end
    join_none
    m_rdata = 16'hC0DE;
    txn(0, 1'b0, 1'b1, 25'h00000AA, '0, g, ac, sa, sdn, sw, srd, swr, dv);
    chk("ovr_acked", 128'(ac > 100), 128'(1));
    chk("ovr_dout", 128'(dv), 128'(16'hC0DE));
    chk("overrun_set", 128'(bus.rfsh_overrun), 128'(1));
    repeat (100) @(negedge clk);
    chk("overrun_sticky", 128'(bus.rfsh_overrun), 128'(1));
    force_busy = 1'b1;
    m_rdata = 16'h7777;
    drive(1, 1'b1, 1'b0, 1'b1, 25'h123, '0);
    for (int n = 0; n < 100 && !bus.sd_rd; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("mid_in_flight", 128'(bus.sd_rd), 128'(1));
    reset_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 128'(outs()), 128'(0));
    force_busy = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    txn(1, 1'b0, 1'b1, 25'h123, '0, g, ac, sa, sdn, sw, srd, swr, dv);
    chk("post_reset_grant", 128'(g), 128'(257));
    chk("post_reset_ack", 128'(ac), 128'(265));
    chk("post_reset_dout", 128'(dv), 128'(16'h7777));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
